// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N-to-1 stream multiplexer: selection modes and FSM encoding.
package stream_mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester strictly after ptr wins, wrapping modulo N.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] grant,
    output logic                 grant_valid
);

    localparam int SW = $clog2(N);

    logic [SW-1:0] idx_s;

    // Scan from ptr+1 upward; once a requester is found later ones cannot override it.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx_s       = '0;
        for (int i = 1; i <= N; i++) begin
            idx_s       = SW'((int'(ptr) + i) % N);
            grant       = (req[idx_s] && !grant_valid) ? idx_s : grant;
            grant_valid = grant_valid | req[idx_s];
        end
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream multiplexer with packet locking, external or round-robin
// selection and a registered output stage.
module stream_mux_nto1
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int MODE  = MODE_SEL
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   s_data,
    input  logic [N-1:0]         s_valid,
    input  logic [N-1:0]         s_last,
    output logic [N-1:0]         s_ready,
    input  logic [$clog2(N)-1:0] sel,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_valid,
    output logic                 m_last,
    output logic [$clog2(N)-1:0] m_chan,
    input  logic                 m_ready
);

    localparam int SW = $clog2(N);
    localparam int NP = 1 << SW;

    state_e            state_q;
    logic [SW-1:0]     ptr_q;
    logic [SW-1:0]     lock_q;
    logic [WIDTH-1:0]  m_data_q;
    logic              m_valid_q;
    logic              m_last_q;
    logic [SW-1:0]     m_chan_q;

    // Inputs padded to a power of two so an out-of-range sel reads as "not valid".
    logic [NP-1:0]       valid_ext_s;
    logic [NP-1:0]       last_ext_s;
    logic [NP*WIDTH-1:0] data_ext_s;
    logic [SW-1:0]       arb_grant_s;
    logic                arb_valid_s;
    logic [SW-1:0]       grant_s;
    logic                grant_valid_s;
    logic                load_s;
    logic                accept_s;
    logic                beat_last_s;
    logic [WIDTH-1:0]    beat_data_s;

    assign valid_ext_s = NP'(s_valid);
    assign last_ext_s  = NP'(s_last);
    assign data_ext_s  = (NP*WIDTH)'(s_data);

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req         (s_valid),
        .ptr         (ptr_q),
        .grant       (arb_grant_s),
        .grant_valid (arb_valid_s)
    );

    // Grant source: held lock, round-robin arbiter, or external select.
    always_comb begin
        grant_s       = '0;
        grant_valid_s = 1'b0;
        if (state_q == ST_LOCKED) begin
            grant_s       = lock_q;
            grant_valid_s = valid_ext_s[lock_q];
        end else if (MODE == MODE_RR) begin
            grant_s       = arb_grant_s;
            grant_valid_s = arb_valid_s;
        end else begin
            grant_s       = sel;
            grant_valid_s = valid_ext_s[sel];
        end
    end

    assign load_s      = !m_valid_q | m_ready;
    assign accept_s    = load_s & grant_valid_s & !rst;
    assign beat_last_s = last_ext_s[grant_s];
    assign beat_data_s = data_ext_s[int'(grant_s)*WIDTH +: WIDTH];
    assign s_ready     = accept_s ? (N'(1'b1) << grant_s) : '0;

    // Packet FSM, rotation pointer and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= SW'(N - 1);
            lock_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_chan_q  <= '0;
        end else begin
            if (accept_s) begin
                m_data_q  <= beat_data_s;
                m_last_q  <= beat_last_s;
                m_chan_q  <= grant_s;
                m_valid_q <= 1'b1;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
            // Priority rotates per packet, so only a completed packet moves the pointer.
            if (accept_s && beat_last_s) begin
                ptr_q <= grant_s;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept_s && !beat_last_s) begin
                        lock_q  <= grant_s;
                        state_q <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (accept_s && beat_last_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_chan  = m_chan_q;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Bench for stream_mux_nto1: one external-select instance, one round-robin instance.
module tb_stream_mux_nto1;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int NV = 18;

    typedef struct {
        logic [1:0]  chan;
        logic [7:0]  data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        m_ready;
        logic [3:0]  exp_ready;
        logic        exp_mvalid;
        logic [7:0]  exp_mdata;
        logic        exp_mlast;
        logic [1:0]  exp_mchan;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]  sel0, sel1;
    logic [3:0]  s_valid0, s_last0, s_ready0, s_valid1, s_last1, s_ready1;
    logic [31:0] s_data0, s_data1;
    logic [7:0]  m_data0, m_data1;
    logic        m_valid0, m_last0, m_ready0, m_valid1, m_last1, m_ready1;
    logic [1:0]  m_chan0, m_chan1;

    int vectors     = 0;
    int miscompares = 0;

    beat_t pq[N][$];
    beat_t exp_q[$];
    int    order_tbl[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    vec_t  tbl[NV];

    always #5 clk = ~clk;

    stream_mux_nto1 #(.WIDTH(W), .N(N), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .s_data(s_data0), .s_valid(s_valid0), .s_last(s_last0),
        .s_ready(s_ready0), .sel(sel0), .m_data(m_data0), .m_valid(m_valid0),
        .m_last(m_last0), .m_chan(m_chan0), .m_ready(m_ready0)
    );

    stream_mux_nto1 #(.WIDTH(W), .N(N), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .s_data(s_data1), .s_valid(s_valid1), .s_last(s_last1),
        .s_ready(s_ready1), .sel(sel1), .m_data(m_data1), .m_valid(m_valid1),
        .m_last(m_last1), .m_chan(m_chan1), .m_ready(m_ready1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        s_valid0 = 4'b0000;
        s_valid1 = 4'b0000;
        s_last1  = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic fill(input int np_lo, input int np_hi, input int len_lo, input int len_hi);
        beat_t bt;
        int    npk;
        int    len;
        for (int c = 0; c < N; c++) begin
            npk = $urandom_range(np_hi, np_lo);
            for (int p = 0; p < npk; p++) begin
                len = $urandom_range(len_hi, len_lo);
                for (int b = 0; b < len; b++) begin
                    bt.chan = 2'(c);
                    bt.data = 8'($urandom);
                    bt.last = (b == len - 1);
                    pq[c].push_back(bt);
                end
            end
        end
    endtask

    // Whole packets are served in rotating order, starting after channel N-1.
    task automatic build_expected();
        beat_t tmp[N][$];
        beat_t bt;
        int    prev;
        int    found;
        int    c;
        exp_q.delete();
        for (int i = 0; i < N; i++) tmp[i] = pq[i];
        prev = N - 1;
        while (1) begin
            found = -1;
            for (int k = 1; k <= N; k++) begin
                c = (prev + k) % N;
                if (found < 0 && tmp[c].size() > 0) found = c;
            end
            if (found < 0) break;
            do begin
                bt = tmp[found].pop_front();
                exp_q.push_back(bt);
            end while (!bt.last);
            prev = found;
        end
    endtask

    task automatic drive1(input bit force_ready);
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0) begin
                s_valid1[i]         = 1'b1;
                s_last1[i]          = pq[i][0].last;
                s_data1[i*W +: W]   = pq[i][0].data;
            end else begin
                s_valid1[i] = 1'b0;
                s_last1[i]  = 1'b0;
            end
        end
        m_ready1 = force_ready ? 1'b1 : ($urandom_range(9, 0) < 7);
    endtask

    task automatic run_stream(input bit force_ready, input int order_n, input int max_cycles);
        bit         fired[N];
        bit         stall;
        logic [7:0] pdata;
        logic       plast;
        logic [1:0] pchan;
        beat_t      bt;
        int         cyc;
        int         left;
        stall = 1'b0;
        pdata = '0;
        plast = 1'b0;
        pchan = '0;
        cyc   = 0;
        while (exp_q.size() > 0 && cyc < max_cycles) begin
            drive1(force_ready);
            @(negedge clk);
            if (stall) begin
                check("stall m_valid", m_valid1, 1);
                check("stall m_data", m_data1, pdata);
                check("stall m_last", m_last1, plast);
                check("stall m_chan", m_chan1, pchan);
            end
            check("s_ready onehot", ($countones(s_ready1) <= 1), 1);
            for (int i = 0; i < N; i++) fired[i] = s_valid1[i] & s_ready1[i];
            if (m_valid1 && m_ready1) begin
                bt = exp_q.pop_front();
                check("sb m_chan", m_chan1, bt.chan);
                check("sb m_data", m_data1, bt.data);
                check("sb m_last", m_last1, bt.last);
            end
            stall = m_valid1 & !m_ready1;
            pdata = m_data1;
            plast = m_last1;
            pchan = m_chan1;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (fired[i] && pq[i].size() > 0) void'(pq[i].pop_front());
            end
            if (cyc < order_n) begin
                check($sformatf("rr m_valid c%0d", cyc), m_valid1, 1);
                check($sformatf("rr order c%0d", cyc), m_chan1, order_tbl[cyc]);
            end
            cyc++;
        end
        check("stream beats outstanding", exp_q.size(), 0);
        left = 0;
        for (int i = 0; i < N; i++) left += pq[i].size();
        check("producer beats left", left, 0);
        drive1(1'b1);
        @(posedge clk); #1;
        check("no extra beat", m_valid1, 0);
    endtask

    initial begin
        tbl[0]  = '{2'd2, 4'b0100, 4'b0000, 32'h0010_0000, 1'b1, 4'b0100, 1'b1, 8'h10, 1'b0, 2'd2};
        tbl[1]  = '{2'd2, 4'b0100, 4'b0100, 32'h0020_0000, 1'b1, 4'b0100, 1'b1, 8'h20, 1'b1, 2'd2};
        tbl[2]  = '{2'd2, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h20, 1'b1, 2'd2};
        tbl[3]  = '{2'd1, 4'b1010, 4'b0000, 32'hC100_A100, 1'b1, 4'b0010, 1'b1, 8'hA1, 1'b0, 2'd1};
        tbl[4]  = '{2'd3, 4'b1010, 4'b0000, 32'hC100_A200, 1'b1, 4'b0010, 1'b1, 8'hA2, 1'b0, 2'd1};
        tbl[5]  = '{2'd3, 4'b1010, 4'b1010, 32'hC100_A300, 1'b1, 4'b0010, 1'b1, 8'hA3, 1'b1, 2'd1};
        tbl[6]  = '{2'd3, 4'b1000, 4'b1000, 32'hC100_0000, 1'b1, 4'b1000, 1'b1, 8'hC1, 1'b1, 2'd3};
        tbl[7]  = '{2'd0, 4'b0001, 4'b0000, 32'h0000_0051, 1'b0, 4'b0000, 1'b1, 8'hC1, 1'b1, 2'd3};
        tbl[8]  = '{2'd0, 4'b0001, 4'b0000, 32'h0000_0051, 1'b1, 4'b0001, 1'b1, 8'h51, 1'b0, 2'd0};
        for (int k = 9; k < 14; k++)
            tbl[k] = '{2'd1, 4'b0011, 4'b0000, 32'h0000_6652, 1'b0, 4'b0000, 1'b1, 8'h51, 1'b0, 2'd0};
        tbl[14] = '{2'd1, 4'b0011, 4'b0011, 32'h0000_6652, 1'b1, 4'b0001, 1'b1, 8'h52, 1'b1, 2'd0};
        tbl[15] = '{2'd1, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b1, 8'h52, 1'b1, 2'd0};
        tbl[16] = '{2'd1, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h52, 1'b1, 2'd0};
        tbl[17] = '{2'd1, 4'b0010, 4'b0010, 32'h0000_7700, 1'b1, 4'b0010, 1'b1, 8'h77, 1'b1, 2'd1};

        rst      = 1'b1;
        sel0     = 2'd0;
        sel1     = 2'd0;
        s_valid0 = 4'b1111;
        s_last0  = 4'b0000;
        s_data0  = 32'hDEAD_BEEF;
        m_ready0 = 1'b1;
        s_valid1 = 4'b1111;
        s_last1  = 4'b0000;
        s_data1  = 32'hCAFE_F00D;
        m_ready1 = 1'b1;

        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            check($sformatf("reset%0d s_ready0", r), s_ready0, 0);
            check($sformatf("reset%0d s_ready1", r), s_ready1, 0);
            @(posedge clk); #1;
            check($sformatf("reset%0d u0 outputs", r), {m_valid0, m_last0, m_chan0, m_data0}, 0);
            check($sformatf("reset%0d u1 outputs", r), {m_valid1, m_last1, m_chan1, m_data1}, 0);
        end
        rst      = 1'b0;
        s_valid1 = 4'b0000;

        for (int k = 0; k < NV; k++) begin
            sel0     = tbl[k].sel;
            s_valid0 = tbl[k].valid;
            s_last0  = tbl[k].last;
            s_data0  = tbl[k].data;
            m_ready0 = tbl[k].m_ready;
            @(negedge clk);
            check($sformatf("v%0d s_ready", k), s_ready0, tbl[k].exp_ready);
            @(posedge clk); #1;
            check($sformatf("v%0d m_valid", k), m_valid0, tbl[k].exp_mvalid);
            check($sformatf("v%0d m_data", k), m_data0, tbl[k].exp_mdata);
            check($sformatf("v%0d m_last", k), m_last0, tbl[k].exp_mlast);
            check($sformatf("v%0d m_chan", k), m_chan0, tbl[k].exp_mchan);
        end
        s_valid0 = 4'b0000;

        reset_dut();
        fill(3, 3, 2, 2);
        build_expected();
        run_stream(1'b1, 9, 200);

        reset_dut();
        s_valid1 = 4'b0010;
        s_last1  = 4'b0000;
        s_data1  = 32'h0000_1100;
        m_ready1 = 1'b1;
        @(posedge clk); #1;
        check("rm beat1 m_valid", m_valid1, 1);
        check("rm beat1 m_chan", m_chan1, 1);
        s_data1 = 32'h0000_1200;
        rst     = 1'b1;
        @(negedge clk);
        check("rm s_ready in reset", s_ready1, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rm m_valid after reset", m_valid1, 0);
        check("rm m_data after reset", m_data1, 0);
        check("rm m_chan after reset", m_chan1, 0);
        s_valid1 = 4'b0011;
        s_last1  = 4'b0011;
        s_data1  = 32'h0000_1301;
        @(negedge clk);
        check("rm first grant s_ready", s_ready1, 4'b0001);
        @(posedge clk); #1;
        check("rm first grant m_chan", m_chan1, 0);
        check("rm first grant m_data", m_data1, 8'h01);
        s_valid1 = 4'b0000;

        for (int r = 0; r < 3; r++) begin
            reset_dut();
            fill(0, 5, 1, 4);
            build_expected();
            run_stream(1'b0, 0, 3000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
